// File: rtl/psram_qspi_sequencer_pkg.sv
// Shared SPI types plus the PSRAM burst sequencer state set and command opcodes.
package psram_qspi_sequencer_pkg;

    typedef enum logic [1:0] {
        SPI_MODE_1,
        SPI_MODE_4_OUTPUTS,
        SPI_MODE_4_INPUTS,
        SPI_MODE_WAIT
    } SpiMode;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        WAIT,
        DATA,
        GAP
    } PsramSeqState;

    localparam logic [7:0] PSRAM_CMD_QUAD_WRITE = 8'h38;
    localparam logic [7:0] PSRAM_CMD_QUAD_READ  = 8'hEB;

    function automatic logic [3:0] spi_mode_oe(input SpiMode mode);
        case (mode)
            SPI_MODE_1:         return 4'b0001;
            SPI_MODE_4_OUTPUTS: return 4'b1111;
            default:            return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/qspi_shift_unit.sv
// SCLK phase generator and 1/4-bit shifter for the QSPI pins; samples sio_in
// at the end of each SCLK high phase.
module qspi_shift_unit
    import psram_qspi_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        active,
    input  SpiMode      mode,
    input  logic        load,
    input  logic [31:0] load_data,
    input  logic [3:0]  sio_in,
    output logic        sclk,
    output logic        sclk_end,
    output logic [3:0]  sio_out,
    output logic [3:0]  sio_oe,
    output logic [31:0] rx_data
);

    logic        phase;
    logic [31:0] sreg;

    assign sclk     = active & phase;
    assign sclk_end = active & phase;
    assign sio_oe   = active ? spi_mode_oe(mode) : 4'b0000;

    always_comb begin
        sio_out = 4'b0000;
        if (active) begin
            case (mode)
                SPI_MODE_1:         sio_out = {3'b000, sreg[31]};
                SPI_MODE_4_OUTPUTS: sio_out = sreg[31:28];
                default:            sio_out = 4'b0000;
            endcase
        end
    end

    // Shifting on the edge that closes phase 1 puts the next bit on the pins
    // for the following phase 0; a load overrides the shift at state changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase   <= 1'b0;
            sreg    <= '0;
            rx_data <= '0;
        end else begin
            phase <= active ? ~phase : 1'b0;
            if (load) begin
                sreg    <= load_data;
                rx_data <= '0;
            end else if (sclk_end) begin
                if (mode == SPI_MODE_1)         sreg <= {sreg[30:0], 1'b0};
                if (mode == SPI_MODE_4_OUTPUTS) sreg <= {sreg[27:0], 4'h0};
                if (mode == SPI_MODE_4_INPUTS)  rx_data <= {rx_data[27:0], sio_in};
            end
        end
    end

endmodule

// File: rtl/psram_qspi_sequencer.sv
// Single-burst PSRAM read/write sequencer: command (1-bit), address (quad),
// optional dummy phase, data nibbles, then a chip-enable gap.
module psram_qspi_sequencer
    import psram_qspi_sequencer_pkg::*;
#(
    parameter int WAIT_CLOCKS = 6,
    parameter int GAP_CYCLES  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [23:0] req_addr,
    input  logic [1:0]  req_len,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        psram_ce_n,
    output logic        psram_sclk,
    output logic [3:0]  sio_out,
    output logic [3:0]  sio_oe,
    input  logic [3:0]  sio_in
);

    PsramSeqState state, state_n;
    SpiMode       mode;
    logic [7:0]   cnt, limit;
    logic         wr;
    logic [23:0]  addr;
    logic [1:0]   len;
    logic [31:0]  wdata;
    logic         active, sclk_end, last, load, done;
    logic [31:0]  load_data, rx_data, rx_final, rdata_final;

    assign active     = state inside {CMD, ADDR, WAIT, DATA};
    assign psram_ce_n = ~active;
    assign req_ready  = (state == IDLE);
    assign rsp_valid  = (state == GAP) && (cnt == 8'd0);

    qspi_shift_unit u_shift (
        .clk       (clk),
        .rst_n     (rst_n),
        .active    (active),
        .mode      (mode),
        .load      (load),
        .load_data (load_data),
        .sio_in    (sio_in),
        .sclk      (psram_sclk),
        .sclk_end  (sclk_end),
        .sio_out   (sio_out),
        .sio_oe    (sio_oe),
        .rx_data   (rx_data)
    );

    always_comb begin
        mode  = SPI_MODE_WAIT;
        limit = 8'd0;
        case (state)
            CMD:  begin mode = SPI_MODE_1;         limit = 8'd8; end
            ADDR: begin mode = SPI_MODE_4_OUTPUTS; limit = 8'd6; end
            WAIT: begin mode = SPI_MODE_WAIT;      limit = 8'(WAIT_CLOCKS); end
            DATA: begin
                mode  = wr ? SPI_MODE_4_OUTPUTS : SPI_MODE_4_INPUTS;
                limit = {4'd0, ({1'b0, len} + 3'd1), 1'b0};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_n   = state;
        load      = 1'b0;
        load_data = '0;
        done      = 1'b0;
        last      = sclk_end && (cnt == limit - 8'd1);
        case (state)
            IDLE: if (req_valid) begin
                state_n   = CMD;
                load      = 1'b1;
                load_data = {req_write ? PSRAM_CMD_QUAD_WRITE : PSRAM_CMD_QUAD_READ, 24'h0};
            end
            CMD: if (last) begin
                state_n   = ADDR;
                load      = 1'b1;
                load_data = {addr, 8'h0};
            end
            ADDR: if (last) begin
                load = 1'b1;
                if (wr) begin
                    state_n   = DATA;
                    load_data = {wdata[7:0], wdata[15:8], wdata[23:16], wdata[31:24]};
                end else begin
                    state_n = (WAIT_CLOCKS > 0) ? WAIT : DATA;
                end
            end
            WAIT: if (last) begin
                state_n = DATA;
                load    = 1'b1;
            end
            DATA: if (last) begin
                state_n = GAP;
                done    = 1'b1;
            end
            GAP: if (cnt == 8'(GAP_CYCLES - 1)) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // The last nibble lands in the shifter on the same edge that completes the
    // burst, so assemble from the value it is about to take.
    assign rx_final = {rx_data[27:0], sio_in};

    always_comb begin
        case (len)
            2'd0:    rdata_final = {24'h0, rx_final[7:0]};
            2'd1:    rdata_final = {16'h0, rx_final[7:0], rx_final[15:8]};
            2'd2:    rdata_final = {8'h0, rx_final[7:0], rx_final[15:8], rx_final[23:16]};
            default: rdata_final = {rx_final[7:0], rx_final[15:8], rx_final[23:16], rx_final[31:24]};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            wr        <= 1'b0;
            addr      <= '0;
            len       <= '0;
            wdata     <= '0;
            rsp_rdata <= '0;
        end else begin
            state <= state_n;
            if (state_n != state)             cnt <= '0;
            else if (state == GAP || sclk_end) cnt <= cnt + 8'd1;
            if (state == IDLE && req_valid) begin
                wr    <= req_write;
                addr  <= req_addr;
                len   <= req_len;
                wdata <= req_wdata;
            end
            if (done) rsp_rdata <= wr ? 32'h0 : rdata_final;
        end
    end

endmodule

// File: tb/tb_psram_qspi_sequencer.sv
// Scoreboarded bench: pin-level capture of each burst, PSRAM read model,
// and latency/handshake checks against expectations queued at stimulus time.
module tb_psram_qspi_sequencer;

    localparam int WAIT_CLOCKS = 6;
    localparam int GAP_CYCLES  = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write;
    logic [23:0] req_addr;
    logic [1:0]  req_len;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        psram_ce_n, psram_sclk;
    logic [3:0]  sio_out, sio_oe;
    logic [3:0]  sio_in = 4'h0;

    psram_qspi_sequencer #(.WAIT_CLOCKS(WAIT_CLOCKS), .GAP_CYCLES(GAP_CYCLES)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .psram_ce_n(psram_ce_n), .psram_sclk(psram_sclk),
        .sio_out(sio_out), .sio_oe(sio_oe), .sio_in(sio_in)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [23:0] addr;
        logic [1:0]  len;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          lat;
    } exp_t;

    exp_t       sb[$];
    int         acc_q[$];
    logic [7:0] sclk_q[$];
    logic [7:0] mem [4];
    int n_vec = 0, n_err = 0;
    int cyc = 0, acc_n = 0, rsp_n = 0, busy_ready = 0;
    int ce_hi = 0, last_gap = 0, last_acc_cyc = 0, last_rsp_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    task automatic check_txn(input int c);
        exp_t e;
        int a, n, d0, bad;
        logic [7:0]  gc;
        logic [23:0] ga;
        logic [31:0] gw, mask;
        e = sb.pop_front();
        a = -1000;
        if (acc_q.size() > 0) a = acc_q.pop_front();
        n = 14 + (e.wr ? 0 : WAIT_CLOCKS) + 2 * (int'(e.len) + 1);
        chk("latency", 32'(c - a), 32'(e.lat));
        chk("sclk_count", 32'(sclk_q.size()), 32'(n));
        if (sclk_q.size() >= n) begin
            gc = '0; ga = '0; gw = '0; bad = 0;
            for (int i = 0; i < 8; i++) begin
                gc = {gc[6:0], sclk_q[i][0]};
                if (sclk_q[i][7:4] != 4'b0001) bad++;
            end
            chk("cmd", {24'h0, gc}, {24'h0, e.wr ? 8'h38 : 8'hEB});
            for (int i = 8; i < 14; i++) begin
                ga = {ga[19:0], sclk_q[i][3:0]};
                if (sclk_q[i][7:4] != 4'b1111) bad++;
            end
            chk("addr", {8'h0, ga}, {8'h0, e.addr});
            d0 = 14;
            if (!e.wr) begin
                for (int i = 14; i < 14 + WAIT_CLOCKS; i++) if (sclk_q[i] != 8'h00) bad++;
                d0 = 14 + WAIT_CLOCKS;
            end
            for (int i = 0; i < 2 * (int'(e.len) + 1); i++) begin
                if (e.wr) begin
                    gw[8 * (i / 2) + ((i % 2 == 0) ? 4 : 0) +: 4] = sclk_q[d0 + i][3:0];
                    if (sclk_q[d0 + i][7:4] != 4'b1111) bad++;
                end else if (sclk_q[d0 + i][7:4] != 4'b0000) bad++;
            end
            chk("pin_oe", 32'(bad), 32'd0);
            if (e.wr) begin
                mask = 32'hFFFF_FFFF >> (8 * (3 - int'(e.len)));
                chk("wdata", gw, e.wdata & mask);
            end
        end
        chk("rdata", rsp_rdata, e.rdata);
        sclk_q.delete();
    endtask

    // Pin monitor and PSRAM model: read nibbles are presented during SCLK high.
    always @(negedge clk) begin
        if (rst_n) begin
            if (req_valid && req_ready) begin
                acc_q.push_back(cyc);
                last_acc_cyc = cyc;
                acc_n++;
            end
            if (psram_ce_n) ce_hi++;
            else begin
                if (ce_hi != 0) last_gap = ce_hi;
                ce_hi = 0;
                if (req_ready) busy_ready++;
            end
            if (!psram_ce_n && psram_sclk) begin
                int r, j;
                r = sclk_q.size() - 14 - WAIT_CLOCKS;
                sio_in = 4'h0;
                if (sb.size() > 0 && !sb[0].wr && r >= 0) begin
                    j = r / 2;
                    if (j < 4) sio_in = (r % 2 == 0) ? mem[j][7:4] : mem[j][3:0];
                end
                sclk_q.push_back({sio_oe, sio_out});
            end
            if (rsp_valid) begin
                rsp_n++;
                last_rsp_cyc = cyc;
                if (sb.size() == 0) chk("spurious_rsp", 32'd1, 32'd0);
                else check_txn(cyc);
            end
        end
    end

    task automatic send(input logic w, input logic [23:0] a, input logic [1:0] l,
                        input logic [31:0] d, input bit hold);
        exp_t e;
        int n0, t;
        e.wr = w; e.addr = a; e.len = l; e.wdata = d; e.rdata = '0;
        if (!w) for (int k = 0; k <= int'(l); k++) e.rdata[8 * k +: 8] = mem[k];
        e.lat = 29 + (w ? 0 : 2 * WAIT_CLOCKS) + 4 * (int'(l) + 1);
        sb.push_back(e);
        req_write = w; req_addr = a; req_len = l; req_wdata = d; req_valid = 1'b1;
        n0 = acc_n; t = 0;
        while (acc_n == n0 && t < 200) begin @(posedge clk); t++; end
        #1;
        if (!hold) req_valid = 1'b0;
        if (acc_n == n0) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        int t = 0;
        while (sb.size() != 0 && t < 300) begin @(posedge clk); t++; end
        if (sb.size() != 0) begin
            chk("done_timeout", 32'(sb.size()), 32'd0);
            sb.delete(); acc_q.delete(); sclk_q.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int r0;
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0;
        req_addr = '0; req_len = '0; req_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'h0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_ce_n", {31'h0, psram_ce_n}, 32'd1);
        chk("rst_sclk", {31'h0, psram_sclk}, 32'd0);
        chk("rst_sio", {24'h0, sio_oe, sio_out}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        send(1'b1, 24'h123456, 2'd0, 32'hDEAD_BEA5, 1'b0);
        wait_idle();

        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
        send(1'b0, 24'h000000, 2'd3, 32'h0, 1'b0);
        wait_idle();

        mem[0] = 8'hDE; mem[1] = 8'hAD; mem[2] = 8'h77; mem[3] = 8'h99;
        send(1'b0, 24'h00_0400, 2'd1, 32'h0, 1'b0);
        wait_idle();

        busy_ready = 0;
        send(1'b1, 24'hABCDEF, 2'd3, 32'h8765_4321, 1'b0);
        repeat (30) begin
            @(posedge clk); #1;
            req_addr = 24'($urandom); req_write = ~req_write;
        end
        wait_idle();
        chk("ready_while_busy", 32'(busy_ready), 32'd0);

        mem[0] = 8'h5A; mem[1] = 8'hC3; mem[2] = 8'h0F; mem[3] = 8'hF0;
        send(1'b1, 24'h0F0F0F, 2'd1, 32'h0000_BEEF, 1'b1);
        send(1'b0, 24'h3C3C00, 2'd2, 32'h0, 1'b0);
        chk("b2b_accept_gap", 32'(last_acc_cyc - last_rsp_cyc), 32'(GAP_CYCLES));
        wait_idle();
        chk("b2b_ce_high_ge2", {31'h0, last_gap >= 2}, 32'd1);

        send(1'b0, 24'h111110, 2'd3, 32'h0, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        r0 = rsp_n;
        rst_n = 1'b0;
        #1;
        chk("abort_ce_n", {31'h0, psram_ce_n}, 32'd1);
        chk("abort_oe", {28'h0, sio_oe}, 32'd0);
        chk("abort_rdata", rsp_rdata, 32'd0);
        sb.delete(); acc_q.delete(); sclk_q.delete();
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("abort_ready", {31'h0, req_ready}, 32'd1);
        repeat (60) @(posedge clk);
        #1;
        chk("abort_no_rsp", 32'(rsp_n - r0), 32'd0);

        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < 4; k++) mem[k] = 8'($urandom);
            send(1'($urandom), 24'($urandom), 2'($urandom), $urandom, 1'b0);
            wait_idle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
